// File: rtl/div_pkg.sv
// div_pkg: shared formats, FSM states and helpers for the
// Newton-Raphson reciprocal / quotient approximation engine.
package div_pkg;

    localparam int SIG_W        = 58;
    localparam int E_W          = 55;
    localparam int EB_W         = 115;
    localparam int X_W          = 57;
    localparam int PROD_W       = 2 * SIG_W;
    localparam int SP_MASK_LSBS = 29;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_T,
        MUL_X,
        QUOT,
        PROD,
        DONE
    } state_t;

    // Drop the digits below single-precision resolution.
    function automatic logic [E_W-1:0] sp_trunc(
        input logic [E_W-1:0] e,
        input logic           dbl
    );
        logic [E_W-1:0] m;
        m = dbl ? e : {e[E_W-1:SP_MASK_LSBS], {SP_MASK_LSBS{1'b0}}};
        return m;
    endfunction

endpackage

// File: rtl/recip_lut.sv
// recip_lut: reciprocal seed ROM indexed by the leading divisor
// fraction bits; the entry's leading one is implicit.
module recip_lut #(
    parameter int LUT_BITS = 8
) (
    input  logic [LUT_BITS-1:0] i_idx,
    output logic [LUT_BITS-1:0] o_entry
);

    // 2^(L+1) / (1 + (i+0.5)/2^L), reduced to integer arithmetic.
    function automatic logic [LUT_BITS-1:0] seed(input int i);
        longint num;
        longint den;
        longint q;
        num = longint'(1) << (2 * LUT_BITS + 2);
        den = (longint'(1) << (LUT_BITS + 1)) + 2 * longint'(i) + 1;
        q   = num / den;
        return LUT_BITS'(q);
    endfunction

    logic [LUT_BITS-1:0] w_rom [2**LUT_BITS];

    for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_rom
        assign w_rom[g] = seed(g);
    end

    assign o_entry = w_rom[i_idx];

endmodule

// File: rtl/div_nr_iter.sv
// div_nr_iter: sequential Newton-Raphson reciprocal and quotient
// approximation engine feeding the divide rounding-selection stage.
module div_nr_iter
    import div_pkg::*;
#(
    parameter int LUT_BITS = 8,
    parameter int ITER_SP  = 2,
    parameter int ITER_DP  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W-1:0] Da_in,
    input  logic [SIG_W-1:0] Db_in,
    input  logic             db_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] Da,
    output logic [SIG_W-1:0] Db,
    output logic             db,
    output logic [E_W-1:0]   E,
    output logic [EB_W-1:0]  Eb
);

    localparam int ITER_MAX = (ITER_DP > ITER_SP) ? ITER_DP : ITER_SP;
    localparam int CNT_W    = $clog2(ITER_MAX + 1);
    localparam int FRAC_W   = SIG_W - 2;
    localparam int E_SH     = 2 * FRAC_W - (E_W - 2);
    localparam int PAD_W    = X_W - 2 - LUT_BITS;

    state_t             r_state;
    state_t             w_next;
    logic [SIG_W-1:0]   r_da;
    logic [SIG_W-1:0]   r_db;
    logic               r_dbl;
    logic [E_W-1:0]     r_e;
    logic [EB_W-1:0]    r_eb;
    logic [X_W-1:0]     r_x;
    logic [SIG_W-1:0]   r_t;
    logic [CNT_W-1:0]   r_cnt;

    logic [LUT_BITS-1:0] w_seed;
    logic [X_W-1:0]      w_tc;
    logic [SIG_W-1:0]    w_ma;
    logic [SIG_W-1:0]    w_mb;
    logic [PROD_W-1:0]   w_prod;
    logic                w_last;
    logic                w_unused;

    recip_lut #(
        .LUT_BITS (LUT_BITS)
    ) u_lut (
        .i_idx   (r_db[FRAC_W-1 -: LUT_BITS]),
        .o_entry (w_seed)
    );

    // Low 57 bits of ~t give 2 - t - 2^-56, never above 2 - Db*x.
    assign w_tc   = ~r_t[X_W-1:0];
    assign w_last = (r_cnt == CNT_W'(1));

    always_comb begin
        w_ma = '0;
        w_mb = '0;
        unique case (r_state)
            MUL_T: begin
                w_ma = r_db;
                w_mb = SIG_W'(r_x);
            end
            MUL_X: begin
                w_ma = SIG_W'(r_x);
                w_mb = SIG_W'(w_tc);
            end
            QUOT: begin
                w_ma = r_da;
                w_mb = SIG_W'(r_x);
            end
            PROD: begin
                w_ma = SIG_W'(r_e);
                w_mb = r_db;
            end
            default: ;
        endcase
    end

    assign w_prod = PROD_W'(w_ma) * PROD_W'(w_mb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = SEED;
            SEED:    w_next = MUL_T;
            MUL_T:   w_next = MUL_X;
            MUL_X:   w_next = w_last ? QUOT : MUL_T;
            QUOT:    w_next = PROD;
            PROD:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_da  <= '0;
            r_db  <= '0;
            r_dbl <= 1'b0;
            r_e   <= '0;
            r_eb  <= '0;
            r_x   <= '0;
            r_t   <= '0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_da  <= Da_in;
                        r_db  <= Db_in;
                        r_dbl <= db_in;
                        r_cnt <= db_in ? CNT_W'(ITER_DP)
                                       : CNT_W'(ITER_SP);
                    end
                end
                SEED: begin
                    r_x <= {1'b0, 1'b1, w_seed, {PAD_W{1'b0}}};
                end
                MUL_T: begin
                    r_t <= w_prod[FRAC_W +: SIG_W];
                end
                MUL_X: begin
                    r_x   <= w_prod[FRAC_W +: X_W];
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                QUOT: begin
                    r_e <= sp_trunc(w_prod[E_SH +: E_W], r_dbl);
                end
                PROD: begin
                    r_eb <= {2'b00, w_prod[EB_W-3:0]};
                end
                default: ;
            endcase
        end
    end

    assign w_unused  = ^{w_prod[PROD_W-1 -: 2], r_t[SIG_W-1]};

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Da        = r_da;
    assign Db        = r_db;
    assign db        = r_dbl;
    assign E         = r_e;
    assign Eb        = r_eb;

endmodule

// File: tb/tb_div_nr_iter.sv
// tb_div_nr_iter: directed vector table, handshake and reset corner
// cases, and a random sweep against an exact integer error bound.
module tb_div_nr_iter;
    import div_pkg::*;

    localparam logic [SIG_W-1:0] F_1_0  = SIG_W'(1) << 56;
    localparam logic [SIG_W-1:0] F_1_5  = SIG_W'(3) << 55;
    localparam logic [SIG_W-1:0] F_1_25 = SIG_W'(5) << 54;
    localparam logic [SIG_W-1:0] F_MAX  = {1'b0, {57{1'b1}}};
    localparam logic [E_W-1:0]   E_1    = E_W'(1) << 53;
    localparam logic [E_W-1:0]   E_SPU  = E_W'(1) << 29;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] Da_in;
    logic [SIG_W-1:0] Db_in;
    logic             db_in;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] Da;
    logic [SIG_W-1:0] Db;
    logic             db;
    logic [E_W-1:0]   E;
    logic [EB_W-1:0]  Eb;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [SIG_W-1:0] da;
        logic [SIG_W-1:0] dv;
        logic             dp;
        logic [E_W-1:0]   lo;
        logic [E_W-1:0]   hi;
    } vec_t;

    vec_t vecs [9];

    div_nr_iter #(
        .LUT_BITS (8),
        .ITER_SP  (2),
        .ITER_DP  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Da_in     (Da_in),
        .Db_in     (Db_in),
        .db_in     (db_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Da        (Da),
        .Db        (Db),
        .db        (db),
        .E         (E),
        .Eb        (Eb)
    );

    always #5 clk = ~clk;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [127:0] act,
                             input logic [127:0] lo,
                             input logic [127:0] hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h..0x%0h",
                     name, act, lo, hi);
        end
    endtask

    // q*2^53 - E must lie in [0, 2 ulp) with ulp = 1 (DP) or 2^29 (SP).
    task automatic check_result(input string name,
                                input logic [SIG_W-1:0] da,
                                input logic [SIG_W-1:0] dv,
                                input logic dp);
        logic [127:0] lhs;
        logic [127:0] rhs;
        logic [127:0] lim;
        lhs = 128'(da) << 53;
        rhs = 128'(E) * 128'(dv);
        lim = 128'(dv) << (dp ? 1 : 30);
        n_tests++;
        if (lhs < rhs || lhs - rhs >= lim) begin
            n_fail++;
            $display("FAIL %s bound: got E=0x%0h, want Da*2^53-E*Db in [0,0x%0h) Da=0x%0h Db=0x%0h dp=%0d",
                     name, E, lim, da, dv, dp);
        end
        check({name, " Eb"}, 128'(Eb), rhs);
        check({name, " Da"}, 128'(Da), 128'(da));
        check({name, " Db"}, 128'(Db), 128'(dv));
        check({name, " db"}, 128'(db), 128'(dp));
        if (!dp) check({name, " sp lsbs"}, 128'(E[SP_MASK_LSBS-1:0]), 128'(0));
    endtask

    task automatic run_op(input string name,
                          input logic [SIG_W-1:0] da,
                          input logic [SIG_W-1:0] dv,
                          input logic dp,
                          input logic early,
                          input int stall,
                          output logic [E_W-1:0] e_out);
        int   lat;
        int   to;
        logic busy_bad;
        to       = 0;
        busy_bad = 1'b0;
        while (!in_ready && to < 50) begin
            @(posedge clk);
            #1;
            to++;
        end
        check({name, " idle ready"}, 128'(in_ready), 128'(1));
        Da_in     = da;
        Db_in     = dv;
        db_in     = dp;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Da_in    = ~da;
        Db_in    = ~dv;
        db_in    = ~dp;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) busy_bad = 1'b1;
        check({name, " latency"}, 128'(lat), 128'(dp ? 9 : 7));
        check({name, " busy ready"}, 128'(busy_bad), 128'(0));
        e_out = E;
        check_result(name, da, dv, dp);
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check({name, " hold valid"}, 128'(out_valid), 128'(1));
            check({name, " hold ready"}, 128'(in_ready), 128'(0));
            check_result({name, " hold"}, da, dv, dp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, " drop valid"}, 128'(out_valid), 128'(0));
        check({name, " rise ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [E_W-1:0]   e;
        logic [SIG_W-1:0] rda;
        logic [SIG_W-1:0] rdv;

        vecs[0] = '{F_1_0, F_1_0, 1'b1, E_1 - E_W'(2), E_1};
        vecs[1] = '{F_1_5, F_1_0, 1'b0,
                    (E_W'(3) << 52) - E_SPU, E_W'(3) << 52};
        vecs[2] = '{F_1_0, F_1_5, 1'b1,
                    55'd6004799503160660, 55'd6004799503160661};
        vecs[3] = '{F_MAX, F_1_0, 1'b1,
                    (E_1 << 1) - E_W'(2), (E_1 << 1) - E_W'(1)};
        vecs[4] = '{F_1_0, F_MAX, 1'b1,
                    (E_1 >> 1) - E_W'(1), E_1 >> 1};
        vecs[5] = '{'0, F_1_5, 1'b0, '0, '0};
        vecs[6] = '{F_1_0, F_1_5, 1'b0,
                    E_W'(11184809) << 29, E_W'(11184810) << 29};
        vecs[7] = '{F_1_25, F_1_25, 1'b1, E_1 - E_W'(1), E_1};
        vecs[8] = '{F_1_25, F_1_25, 1'b0, E_1 - E_SPU, E_1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Da_in     = '0;
        Db_in     = '0;
        db_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 128'(in_ready), 128'(1));
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst Da", 128'(Da), 128'(0));
        check("rst Db", 128'(Db), 128'(0));
        check("rst db", 128'(db), 128'(0));
        check("rst E", 128'(E), 128'(0));
        check("rst Eb", 128'(Eb), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].da, vecs[i].dv,
                   vecs[i].dp, 1'(i % 2), i % 3, e);
            check_rng($sformatf("vec%0d E", i), 128'(e),
                      128'(vecs[i].lo), 128'(vecs[i].hi));
        end

        run_op("stall5", F_1_0, F_1_5, 1'b1, 1'b0, 5, e);
        check_rng("stall5 E", 128'(e), 128'(55'd6004799503160660),
                  128'(55'd6004799503160661));

        Da_in    = F_1_25;
        Db_in    = F_1_5;
        db_in    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 128'(in_ready), 128'(1));
        check("abort out_valid", 128'(out_valid), 128'(0));
        check("abort Da", 128'(Da), 128'(0));
        check("abort Db", 128'(Db), 128'(0));
        check("abort db", 128'(db), 128'(0));
        check("abort E", 128'(E), 128'(0));
        check("abort Eb", 128'(Eb), 128'(0));
        #2;
        rst_n = 1'b1;
        run_op("after abort", F_1_0, F_1_0, 1'b1, 1'b1, 0, e);
        check_rng("after abort E", 128'(e), 128'(E_1 - E_W'(2)),
                  128'(E_1));

        for (int n = 0; n < 300; n++) begin
            rda = {1'b0, 25'($urandom()), $urandom()};
            rdv = {2'b01, 24'($urandom()), $urandom()};
            run_op($sformatf("rnd%0d", n), rda, rdv,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
